rom_ctrl_hash_feeder: RTL



---
 rtl/rom_ctrl_hash_feeder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/rom_ctrl_hash_feeder.sv
// Streams the non-top ROM words into KMAC through a one-entry pipe register, captures the
// top words as the expected digest and raises a sticky error on any counter protocol slip.
module rom_ctrl_hash_feeder #(
    parameter int RomDepth    = 16,
    parameter int RomTopCount = 2,
    parameter int DataWidth   = 32,
    localparam int AW         = (RomDepth > 1) ? $clog2(RomDepth) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             counter_done_i,
    input  logic [AW-1:0]                    data_addr_i,
    input  logic [DataWidth-1:0]             data_i,
    input  logic                             data_vld_i,
    input  logic                             data_last_nontop_i,
    output logic                             data_rdy_o,
    output logic                             kmac_valid_o,
    output logic [DataWidth-1:0]             kmac_data_o,
    output logic                             kmac_last_o,
    input  logic                             kmac_ready_i,
    output logic [DataWidth*RomTopCount-1:0] exp_digest_o,
    output logic                             exp_digest_vld_o,
    output logic                             error_o
);

    localparam int NonTop = RomDepth - RomTopCount;
    localparam logic [AW-1:0] LastNonTopAddr = AW'(NonTop - 1);
    localparam logic [AW-1:0] LastAddr       = AW'(RomDepth - 1);

    typedef enum logic [1:0] {
        Feed,
        ReadTop,
        Done,
        Error
    } state_e;

    state_e state_q, state_d;

    logic [AW-1:0]                    exp_addr_q, exp_addr_d;
    logic                             kmac_valid_q, kmac_valid_d;
    logic                             kmac_last_q, kmac_last_d;
    logic [DataWidth-1:0]             kmac_data_q, kmac_data_d;
    logic [DataWidth*RomTopCount-1:0] digest_q, digest_d;
    logic                             done_prev_q;

    logic accept;
    logic isLastNonTop;
    logic addrErr;
    logic lastErr;
    logic doneErr;
    logic protoErr;

    assign accept       = data_vld_i & data_rdy_o;
    assign isLastNonTop = (data_addr_i == LastNonTopAddr);
    assign addrErr      = accept & (data_addr_i != exp_addr_q);
    assign lastErr      = accept & (data_last_nontop_i != isLastNonTop);
    // Done may only appear once the top words are being read, and must never fall again.
    assign doneErr      = (counter_done_i & (state_q == Feed)) | (done_prev_q & ~counter_done_i);
    assign protoErr     = addrErr | lastErr | doneErr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= Feed;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            Feed: begin
                if (accept && isLastNonTop) begin
                    state_d = ReadTop;
                end
            end
            ReadTop: begin
                if (accept && (data_addr_i == LastAddr) && counter_done_i) begin
                    state_d = Done;
                end
            end
            Done:    state_d = state_q;
            Error:   state_d = state_q;
            default: state_d = Error;
        endcase
        if (protoErr) begin
            state_d = Error;
        end
    end

    always_comb begin
        data_rdy_o       = 1'b0;
        exp_digest_vld_o = 1'b0;
        error_o          = 1'b0;
        unique case (state_q)
            Feed:    data_rdy_o = ~kmac_valid_q | kmac_ready_i;
            ReadTop: data_rdy_o = 1'b1;
            Done:    exp_digest_vld_o = 1'b1;
            Error:   error_o = 1'b1;
            default: error_o = 1'b1;
        endcase
        if (rst_i) begin
            data_rdy_o = 1'b0;
        end
    end

    // Pipe register: drain and reload may coincide; a detected error discards the pending word.
    always_comb begin
        exp_addr_d   = exp_addr_q;
        kmac_valid_d = kmac_valid_q;
        kmac_last_d  = kmac_last_q;
        kmac_data_d  = kmac_data_q;
        digest_d     = digest_q;
        if (accept) begin
            exp_addr_d = exp_addr_q + AW'(1);
        end
        if (kmac_valid_q && kmac_ready_i) begin
            kmac_valid_d = 1'b0;
            kmac_last_d  = 1'b0;
            kmac_data_d  = '0;
        end
        if (accept && (state_q == Feed)) begin
            kmac_valid_d = 1'b1;
            kmac_last_d  = isLastNonTop;
            kmac_data_d  = data_i;
        end
        if (protoErr || (state_q == Error)) begin
            kmac_valid_d = 1'b0;
            kmac_last_d  = 1'b0;
            kmac_data_d  = '0;
        end
        if (accept && (state_q == ReadTop) && !protoErr) begin
            for (int i = 0; i < RomTopCount; i++) begin
                if (data_addr_i == AW'(NonTop + i)) begin
                    digest_d[i*DataWidth +: DataWidth] = data_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exp_addr_q   <= '0;
            kmac_valid_q <= 1'b0;
            kmac_last_q  <= 1'b0;
            kmac_data_q  <= '0;
            digest_q     <= '0;
            done_prev_q  <= 1'b0;
        end else begin
            exp_addr_q   <= exp_addr_d;
            kmac_valid_q <= kmac_valid_d;
            kmac_last_q  <= kmac_last_d;
            kmac_data_q  <= kmac_data_d;
            digest_q     <= digest_d;
            done_prev_q  <= counter_done_i;
        end
    end

    assign kmac_valid_o = kmac_valid_q;
    assign kmac_last_o  = kmac_last_q;
    assign kmac_data_o  = kmac_data_q;
    assign exp_digest_o = digest_q;

endmodule
